// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the push-button counter control stage: FSM state encoding and
// counter direction constants.
package counter_ctrl_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_HOLD_UP   = 2'd1;
   localparam logic [1:0] ST_HOLD_DOWN = 2'd2;
   localparam logic [1:0] ST_LOCK      = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      HOLD_UP   = ST_HOLD_UP,
      HOLD_DOWN = ST_HOLD_DOWN,
      LOCK      = ST_LOCK
   } ctrl_state_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/button_debounce.sv
// One raw button -> synchronised, debounced level plus a one-cycle press pulse.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES edges from pin to level; no backpressure.
module button_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   stable_q, stable_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   press_q, press_d;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], btn_raw};
      stable_d = stable_q;
      cnt_d    = '0;
      // Any agreeing sample restarts the run of mismatches
      if (sync_q[SYNC_STAGES-1] != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = stable_d & ~stable_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign level = stable_q;
   assign press = press_q;

endmodule

// File: rtl/counter_btn_ctrl.sv
// Up/down push-buttons -> registered single-cycle count strobes with auto-repeat and
// conflict lockout; pin-to-strobe latency SYNC_STAGES+DEBOUNCE_CYCLES+1, no backpressure.
module counter_btn_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_RATE     = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up,
   input  logic btn_down,
   output logic enable,
   output logic direction
);

   localparam int TW = $clog2(REPEAT_DELAY + 1);
   localparam logic [TW-1:0] T_FIRST  = TW'(REPEAT_DELAY);
   localparam logic [TW-1:0] T_RELOAD = TW'(REPEAT_DELAY - REPEAT_RATE);

   logic up_level, up_press, dn_level, dn_press;

   button_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_up (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_up),
      .level   (up_level),
      .press   (up_press)
   );

   button_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_dn (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_down),
      .level   (dn_level),
      .press   (dn_press)
   );

   ctrl_state_e   state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
   logic          enable_q, enable_d;
   logic          dir_q, dir_d;
   logic          held_level, other_level;

   assign held_level  = (state_q == HOLD_UP) ? up_level : dn_level;
   assign other_level = (state_q == HOLD_UP) ? dn_level : up_level;

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      enable_d = 1'b0;
      dir_d    = dir_q;
      tmr_inc  = tmr_q + 1'b1;
      case (state_q)
         IDLE: begin
            if ((up_press && (dn_press || dn_level)) || (dn_press && up_level)) begin
               state_d = LOCK;
            end else if (up_press) begin
               state_d  = HOLD_UP;
               enable_d = 1'b1;
               dir_d    = DIR_UP;
               tmr_d    = '0;
            end else if (dn_press) begin
               state_d  = HOLD_DOWN;
               enable_d = 1'b1;
               dir_d    = DIR_DOWN;
               tmr_d    = '0;
            end
         end
         HOLD_UP, HOLD_DOWN: begin
            // A conflicting press outranks both release and a due repeat
            if (other_level) begin
               state_d = LOCK;
            end else if (!held_level) begin
               state_d = IDLE;
            end else if (tmr_inc == T_FIRST) begin
               enable_d = 1'b1;
               dir_d    = (state_q == HOLD_UP) ? DIR_UP : DIR_DOWN;
               tmr_d    = T_RELOAD;
            end else begin
               tmr_d = tmr_inc;
            end
         end
         LOCK: begin
            if (!up_level && !dn_level) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tmr_q    <= '0;
         enable_q <= 1'b0;
         dir_q    <= DIR_DOWN;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         enable_q <= enable_d;
         dir_q    <= dir_d;
      end
   end

   assign enable    = enable_q;
   assign direction = dir_q;

endmodule
